// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: instruction-fetch request/response controller.
//   Issues word fetches on the instruction bus, tracks granted-but-unanswered
//   requests, buffers returned instructions in a small FIFO toward ifu_ifetch,
//   and handles redirects by dropping stale responses still in flight.
// Ports:
//   clk, rst            single clock; asynchronous active-low reset
//   jump_flag_i/addr_i  redirect request and target from execute
//   hold_flag_i         pipeline hold code; hold applies at `Hold_If or above
//   ibus_req_o/addr_o   fetch request and word address (addr = pc)
//   ibus_gnt_i          request accepted when req and gnt are both high
//   ibus_rvalid_i/rdata in-order read response
//   inst_o/addr_o/valid instruction presented to ifu_ifetch (FIFO head)

`ifndef Hold_Flag_Bus
`define Hold_Flag_Bus 2:0
`endif
`ifndef Hold_If
`define Hold_If 3'b010
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_flag_i,
    input  logic [31:0]           jump_addr_i,
    input  logic [`Hold_Flag_Bus] hold_flag_i,
    output logic                  ibus_req_o,
    output logic [31:0]           ibus_addr_o,
    input  logic                  ibus_gnt_i,
    input  logic                  ibus_rvalid_i,
    input  logic [31:0]           ibus_rdata_i,
    output logic [31:0]           inst_o,
    output logic [31:0]           inst_addr_o,
    output logic                  inst_valid_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W:0] CAPACITY = (CNT_W + 1)'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [31:0]        pc_r, pc_s;
    logic [CNT_W-1:0]   out_cnt_r, out_cnt_s;
    logic [CNT_W-1:0]   disc_cnt_r, disc_cnt_s;
    logic [CNT_W-1:0]   if_cnt_r, if_cnt_s;
    logic [CNT_W:0]     inflight_s;
    logic [CNT_W:0]     pend_s;
    logic [PTR_W-1:0]   aq_wr_r, aq_rd_r, if_wr_r, if_rd_r;
    logic [31:0]        aq_mem_r  [MAX_OUTSTANDING];
    logic [31:0]        if_addr_r [MAX_OUTSTANDING];
    logic [31:0]        if_data_r [MAX_OUTSTANDING];
    logic               hold_en_s, req_s, grant_s, rsp_acc_s, pop_s, flush_s;
    logic [31:0]        target_s;
    logic               jump_addr_unused_s;

    // Circular pointer advance for the address queue and instruction FIFO.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    assign hold_en_s          = (hold_flag_i >= `Hold_If);
    assign target_s           = {jump_addr_i[31:2], 2'b00};
    assign jump_addr_unused_s = ^jump_addr_i[1:0];
    assign inflight_s         = {1'b0, out_cnt_r} + {1'b0, if_cnt_r};
    // A redirect withdraws any ungranted request in the same cycle.
    assign req_s              = (state_r == S_RUN) && (inflight_s < CAPACITY) && !jump_flag_i;

    // Next-state, counter and strobe logic; redirect outranks hold, grant and response.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        out_cnt_s  = out_cnt_r;
        disc_cnt_s = disc_cnt_r;
        if_cnt_s   = if_cnt_r;
        pend_s     = '0;
        grant_s    = 1'b0;
        rsp_acc_s  = 1'b0;
        pop_s      = 1'b0;
        flush_s    = 1'b0;
        case (state_r)
            S_BOOT: begin
                state_s = S_RUN;
                if (jump_flag_i) begin
                    pc_s = target_s;
                end else begin
                    pc_s = pc_r;
                end
            end
            S_RUN, S_FLUSH: begin
                if (jump_flag_i) begin
                    flush_s   = 1'b1;
                    pc_s      = target_s;
                    out_cnt_s = '0;
                    if_cnt_s  = '0;
                    // Everything still owed by memory becomes a discard; a response
                    // landing this very cycle is already one of them and is dropped.
                    pend_s = {1'b0, disc_cnt_r} + {1'b0, out_cnt_r};
                    if (ibus_rvalid_i && (pend_s != '0)) begin
                        pend_s = pend_s - (CNT_W + 1)'(1);
                    end else begin
                        pend_s = pend_s;
                    end
                    disc_cnt_s = pend_s[CNT_W-1:0];
                    state_s    = (pend_s != '0) ? S_FLUSH : S_RUN;
                end else begin
                    grant_s   = req_s && ibus_gnt_i;
                    rsp_acc_s = ibus_rvalid_i && (disc_cnt_r == '0) && (out_cnt_r != '0);
                    pop_s     = (if_cnt_r != '0) && !hold_en_s;
                    if (grant_s) begin
                        pc_s = pc_r + 32'd4;
                    end else begin
                        pc_s = pc_r;
                    end
                    if (ibus_rvalid_i && (disc_cnt_r != '0)) begin
                        disc_cnt_s = disc_cnt_r - CNT_W'(1);
                    end else begin
                        disc_cnt_s = disc_cnt_r;
                    end
                    out_cnt_s = out_cnt_r + CNT_W'(grant_s) - CNT_W'(rsp_acc_s);
                    if_cnt_s  = if_cnt_r + CNT_W'(rsp_acc_s) - CNT_W'(pop_s);
                    state_s   = (disc_cnt_s == '0) ? S_RUN : S_FLUSH;
                end
            end
            default: begin
                state_s = S_BOOT;
            end
        endcase
    end

    // Control state: FSM, program counter and occupancy counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_BOOT;
            pc_r       <= RESET_ADDR;
            out_cnt_r  <= '0;
            disc_cnt_r <= '0;
            if_cnt_r   <= '0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            out_cnt_r  <= out_cnt_s;
            disc_cnt_r <= disc_cnt_s;
            if_cnt_r   <= if_cnt_s;
        end
    end

    // Address queue and instruction FIFO storage; a redirect empties both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aq_wr_r <= '0;
            aq_rd_r <= '0;
            if_wr_r <= '0;
            if_rd_r <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                aq_mem_r[i]  <= '0;
                if_addr_r[i] <= '0;
                if_data_r[i] <= '0;
            end
        end else if (flush_s) begin
            aq_wr_r <= '0;
            aq_rd_r <= '0;
            if_wr_r <= '0;
            if_rd_r <= '0;
        end else begin
            if (grant_s) begin
                aq_mem_r[aq_wr_r] <= pc_r;
                aq_wr_r           <= ptr_inc(aq_wr_r);
            end
            if (rsp_acc_s) begin
                aq_rd_r            <= ptr_inc(aq_rd_r);
                if_addr_r[if_wr_r] <= aq_mem_r[aq_rd_r];
                if_data_r[if_wr_r] <= ibus_rdata_i;
                if_wr_r            <= ptr_inc(if_wr_r);
            end
            if (pop_s) begin
                if_rd_r <= ptr_inc(if_rd_r);
            end
        end
    end

    assign ibus_req_o   = req_s;
    assign ibus_addr_o  = pc_r;
    assign inst_valid_o = (if_cnt_r != '0);
    assign inst_o       = inst_valid_o ? if_data_r[if_rd_r] : `INST_NOP;
    assign inst_addr_o  = inst_valid_o ? if_addr_r[if_rd_r] : `ZeroWord;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: a memory model answers granted
// fetches in order, and a scoreboard of expected instruction addresses is
// compared against each instruction the controller hands to ifetch.
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic [2:0]  hold_flag_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_grants = 0;
    logic [31:0] model_pc;
    logic [31:0] exp_q  [$];
    logic [31:0] pend_q [$];

    ifu_fetch_ctrl #(.RESET_ADDR(RESET_ADDR), .MAX_OUTSTANDING(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_gnt_i   (ibus_gnt_i),
        .ibus_rvalid_i(ibus_rvalid_i),
        .ibus_rdata_i (ibus_rdata_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, then observe what the next posedge will do.
    task automatic step(input logic jmp, input logic [31:0] jaddr, input logic [2:0] hflag,
                        input logic [1:0] gsel, input logic rsel);
        logic hold;
        logic [31:0] head;
        @(negedge clk);
        jump_flag_i = jmp;
        jump_addr_i = jaddr;
        hold_flag_i = hflag;
        hold        = (hflag >= 3'd2);
        ibus_gnt_i  = (gsel == 2'd2) ? 1'($urandom_range(0, 1)) : gsel[0];
        if (rsel && (pend_q.size() > 0)) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = mem_data(pend_q[0]);
        end else begin
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = $urandom;
        end
        #1;
        if (ibus_rvalid_i) void'(pend_q.pop_front());
        if (jmp) begin
            check_val("req_during_jump", 32'(ibus_req_o), 32'd0);
            exp_q.delete();
            model_pc = {jaddr[31:2], 2'b00};
        end else begin
            if (inst_valid_o && !hold) begin
                check_val("inst_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    head = exp_q.pop_front();
                    check_val("inst_addr", inst_addr_o, head);
                    check_val("inst_data", inst_o, mem_data(head));
                end
            end
            if (ibus_req_o && ibus_gnt_i) begin
                check_val("fetch_addr", ibus_addr_o, model_pc);
                pend_q.push_back(model_pc);
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
                n_grants++;
            end
        end
    endtask

    // Assert reset for two cycles; release right after a posedge so the next
    // observed cycle is the boot cycle. Stale memory responses stay pending.
    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b0;
        jump_flag_i   = 1'b0;
        jump_addr_i   = 32'd0;
        hold_flag_i   = 3'd0;
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = 32'd0;
        exp_q.delete();
        model_pc = RESET_ADDR;
        #1;
        check_val("rst_req", 32'(ibus_req_o), 32'd0);
        check_val("rst_addr", ibus_addr_o, RESET_ADDR);
        check_val("rst_inst", inst_o, NOP);
        check_val("rst_inst_addr", inst_addr_o, 32'd0);
        check_val("rst_valid", 32'(inst_valid_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if ((pend_q.size() == 0) && (exp_q.size() == 0)) break;
            step(1'b0, 32'd0, 3'd0, 2'd0, 1'b1);
        end
        check_val("drain_done", 32'(pend_q.size() + exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a0;
        int g0;
        rst = 1'b0;
        do_reset();

        // Boot cycle issues nothing, request rises on the second cycle.
        step(1'b0, 32'd0, 3'd0, 2'd1, 1'b1);
        check_val("boot_no_req", 32'(ibus_req_o), 32'd0);
        step(1'b0, 32'd0, 3'd0, 2'd1, 1'b1);
        check_val("run_req", 32'(ibus_req_o), 32'd1);
        check_val("run_addr", ibus_addr_o, RESET_ADDR);
        repeat (20) step(1'b0, 32'd0, 3'd0, 2'd1, 1'b1);
        drain();

        // Hold from boot: two fetches fill the FIFO, head stays put.
        do_reset();
        g0 = n_grants;
        repeat (5) step(1'b0, 32'd0, 3'b010, 2'd1, 1'b1);
        check_val("hold_grants", 32'(n_grants - g0), 32'd2);
        check_val("hold_req", 32'(ibus_req_o), 32'd0);
        check_val("hold_valid", 32'(inst_valid_o), 32'd1);
        check_val("hold_inst_addr", inst_addr_o, RESET_ADDR);
        check_val("hold_inst", inst_o, mem_data(RESET_ADDR));
        repeat (8) step(1'b0, 32'd0, 3'd0, 2'd1, 1'b1);
        drain();

        // Redirect with two outstanding: both stale responses dropped.
        step(1'b0, 32'd0, 3'd0, 2'd1, 1'b0);
        step(1'b0, 32'd0, 3'd0, 2'd1, 1'b0);
        check_val("two_outstanding", 32'(pend_q.size()), 32'd2);
        step(1'b1, 32'h0000_0103, 3'd0, 2'd1, 1'b0);
        step(1'b0, 32'd0, 3'd0, 2'd1, 1'b0);
        check_val("flush_addr", ibus_addr_o, 32'h0000_0100);
        check_val("flush_no_req", 32'(ibus_req_o), 32'd0);
        repeat (10) step(1'b0, 32'd0, 3'd0, 2'd1, 1'b1);
        drain();

        // Redirect coinciding with the only outstanding response.
        step(1'b0, 32'd0, 3'd0, 2'd1, 1'b0);
        step(1'b1, 32'h0000_0200, 3'd0, 2'd0, 1'b1);
        step(1'b0, 32'd0, 3'd0, 2'd0, 1'b0);
        check_val("jmp_rv_req", 32'(ibus_req_o), 32'd1);
        check_val("jmp_rv_addr", ibus_addr_o, 32'h0000_0200);
        repeat (6) step(1'b0, 32'd0, 3'd0, 2'd1, 1'b1);
        drain();

        // Grant withheld for ten cycles, then one grant advances pc by four.
        a0 = model_pc;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'd0, 3'd0, 2'd0, 1'b0);
            check_val("stall_req", 32'(ibus_req_o), 32'd1);
            check_val("stall_addr", ibus_addr_o, a0);
        end
        step(1'b0, 32'd0, 3'd0, 2'd1, 1'b0);
        step(1'b0, 32'd0, 3'd0, 2'd0, 1'b0);
        check_val("stall_advance", ibus_addr_o, a0 + 32'd4);
        drain();

        // Address wrap at the top of memory.
        step(1'b1, 32'hFFFF_FFF9, 3'd0, 2'd1, 1'b1);
        repeat (10) step(1'b0, 32'd0, 3'd0, 2'd1, 1'b1);
        drain();

        // Randomised traffic: grants, responses, holds and redirects.
        for (int i = 0; i < 120; i++) begin
            step(($urandom_range(0, 9) == 0), $urandom, 3'($urandom_range(0, 4)),
                 2'd2, ($urandom_range(0, 3) != 0));
        end
        drain();

        // Reset with two outstanding: late responses must be ignored.
        step(1'b0, 32'd0, 3'd0, 2'd1, 1'b0);
        step(1'b0, 32'd0, 3'd0, 2'd1, 1'b0);
        check_val("pre_reset_outstanding", 32'(pend_q.size()), 32'd2);
        do_reset();
        repeat (12) step(1'b0, 32'd0, 3'd0, 2'd1, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
